// File: rtl/shared_register_arbiter_if.sv
// Bus between four requesters and the shared-register arbiter.
//   req       requester -> arbiter  per-requester write request (level)
//   lock      requester -> arbiter  per-requester chain request
//   reqData   requester -> arbiter  requester i data at [i*W +: W]
//   grant     arbiter -> requester  one-hot owner, 0 when idle
//   regEnb    arbiter -> register   one-cycle load pulse per write
//   regDataIn arbiter -> register   load data, valid while regEnb=1
//   ack       arbiter -> requester  one-hot write-complete pulse
//   busy      arbiter -> requester  arbiter not idle
interface shared_register_arbiter_if #(
    parameter int unsigned W = 16
);
    logic [3:0]     req;
    logic [3:0]     lock;
    logic [4*W-1:0] reqData;
    logic [3:0]     grant;
    logic           regEnb;
    logic [W-1:0]   regDataIn;
    logic [3:0]     ack;
    logic           busy;

    modport master (
        output req, lock, reqData,
        input  grant, regEnb, regDataIn, ack, busy
    );

    modport slave (
        input  req, lock, reqData,
        output grant, regEnb, regDataIn, ack, busy
    );
endinterface

// File: rtl/shared_register_arbiter.sv
// Round-robin write arbiter sharing one enable-loaded W-bit register among
// four requesters, with bounded back-to-back chaining via lock.
//   clock  rising-edge clock
//   reset  asynchronous, active-high
//   bus    slave side of shared_register_arbiter_if (req/lock/reqData in;
//          grant/regEnb/regDataIn/ack/busy out)
// All outputs come straight from registered state.
module shared_register_arbiter #(
    parameter int unsigned W       = 16,
    parameter int unsigned MAXLOCK = 4
) (
    input  logic clock,
    input  logic reset,
    shared_register_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

    state_t       state_q, state_d;
    logic [3:0]   grant_q, grant_d;
    logic [W-1:0] data_q, data_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   owner_q, owner_d;
    logic [3:0]   lcnt_q, lcnt_d;

    logic         win_found;
    logic [1:0]   win_idx;
    logic [1:0]   scan_idx;

    // First requesting index at or after ptr, wrapping modulo 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        scan_idx  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    grant_d = 4'b0001 << win_idx;
                    data_d  = bus.reqData[32'(win_idx) * W +: W];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = ACK;
            end
            ACK: begin
                if (bus.lock[owner_q] && bus.req[owner_q] &&
                    (lcnt_q < 4'(MAXLOCK - 1))) begin
                    // Chain another write; ptr stays so release rotates normally.
                    data_d  = bus.reqData[32'(owner_q) * W +: W];
                    lcnt_d  = lcnt_q + 4'd1;
                    state_d = WRITE;
                end else begin
                    grant_d = '0;
                    lcnt_d  = '0;
                    ptr_d   = owner_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lcnt_q  <= lcnt_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.regEnb    = (state_q == WRITE);
    assign bus.regDataIn = data_q;
    assign bus.ack       = (state_q == ACK) ? grant_q : '0;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_shared_register_arbiter.sv
module tb_shared_register_arbiter;
    localparam int W       = 16;
    localparam int MAXLOCK = 4;

    logic clock;
    logic reset;

    shared_register_arbiter_if #(.W(W)) bus ();

    shared_register_arbiter #(.W(W), .MAXLOCK(MAXLOCK)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Shared register that the arbiter loads.
    logic [W-1:0] shreg;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)           shreg <= '0;
        else if (bus.regEnb) shreg <= bus.regDataIn;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Transaction-level reference: who owns the register, whether the
    // current cycle of the grant is the write or the acknowledge, how many
    // writes the grant has done, and where the rotation starts next.
    int           m_owner;   // -1 when idle
    bit           m_in_ack;  // 0: write cycle, 1: acknowledge cycle
    int           m_writes;
    int           m_ptr;
    logic [W-1:0] m_data;
    logic [W-1:0] m_reg;

    function automatic logic [W-1:0] slice(int i);
        logic [4*W-1:0] all;
        all = bus.reqData;
        return all[i*W +: W];
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_in_ack = 0;
        m_writes = 0;
        m_ptr    = 0;
        m_data   = '0;
        m_reg    = '0;
    endtask

    task automatic model_step();
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && bus.req[(m_ptr + k) % 4]) begin
                    m_owner  = (m_ptr + k) % 4;
                    m_data   = slice(m_owner);
                    m_in_ack = 0;
                    m_writes = 0;
                end
            end
        end else if (!m_in_ack) begin
            m_reg    = m_data;
            m_writes = m_writes + 1;
            m_in_ack = 1;
        end else if (bus.lock[m_owner] && bus.req[m_owner] && m_writes < MAXLOCK) begin
            m_data   = slice(m_owner);
            m_in_ack = 0;
        end else begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(string tag);
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk({tag, ".grant"},     32'(bus.grant),     32'(eg));
        chk({tag, ".regEnb"},    32'(bus.regEnb),    32'(m_owner >= 0 && !m_in_ack));
        chk({tag, ".regDataIn"}, 32'(bus.regDataIn), 32'(m_data));
        chk({tag, ".ack"},       32'(bus.ack),       32'(m_in_ack ? eg : 4'b0000));
        chk({tag, ".busy"},      32'(bus.busy),      32'(m_owner >= 0));
        chk({tag, ".shreg"},     32'(shreg),         32'(m_reg));
    endtask

    task automatic cyc(string tag);
        @(posedge clock);
        if (reset) model_reset();
        else       model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] order [$];
        int         r0_pulses;

        reset       = 1'b1;
        bus.req     = 4'b1111;
        bus.lock    = 4'b0000;
        bus.reqData = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        model_reset();

        // Reset holds everything at zero despite pending requests.
        #2;
        check_all("rst_async");
        cyc("rst_hold");
        cyc("rst_hold2");
        reset = 1'b0;
        cyc("rst_release");
        chk("rst_first_grant", 32'(bus.grant), 32'h1);
        cyc("rst_w");
        bus.req = 4'b0000;
        repeat (3) cyc("rst_drain");

        // Single write from requester 2, then ptr=3 gives requester 3 priority.
        do_reset();
        bus.req = 4'b0100;
        bus.reqData[2*W +: W] = 16'hBEEF;
        cyc("single_c1");
        chk("single_enb", 32'(bus.regEnb), 32'h1);
        chk("single_data", 32'(bus.regDataIn), 32'hBEEF);
        cyc("single_c2");
        chk("single_ack", 32'(bus.ack), 32'h4);
        bus.req = 4'b0000;
        cyc("single_c3");
        chk("single_shreg", 32'(shreg), 32'hBEEF);
        bus.req = 4'b1111;
        cyc("single_ptr");
        chk("single_ptr_grant", 32'(bus.grant), 32'h8);
        bus.req = 4'b0000;
        repeat (3) cyc("single_drain");

        // Round-robin fairness over 12 grants.
        do_reset();
        bus.req = 4'b1111;
        for (int c = 0; c < 36; c++) begin
            cyc("rr");
            if (bus.regEnb) order.push_back(bus.grant);
        end
        chk("rr_pulses", 32'(order.size()), 32'd12);
        for (int k = 0; k < order.size(); k++)
            chk("rr_order", 32'(order[k]), 32'(4'b0001 << (k % 4)));
        bus.req = 4'b0000;
        repeat (3) cyc("rr_drain");

        // Lock cap: requester 0 chains MAXLOCK writes, then requester 1.
        do_reset();
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        r0_pulses = 0;
        for (int c = 1; c <= 9; c++) begin
            cyc("lock");
            if (bus.regEnb && bus.grant == 4'b0001) r0_pulses++;
            if (c % 2 == 1 && c <= 7) chk("lock_pulse_spacing", 32'(bus.regEnb), 32'h1);
        end
        chk("lock_r0_pulses", 32'(r0_pulses), 32'(MAXLOCK));
        cyc("lock_c10");
        chk("lock_next_owner", 32'(bus.grant), 32'h2);
        bus.req  = 4'b0000;
        bus.lock = 4'b0000;
        repeat (4) cyc("lock_drain");

        // Wrap: requester 3 releases, late arrivals go to requester 0.
        do_reset();
        bus.req = 4'b1000;
        cyc("wrap_w");
        cyc("wrap_ack");
        bus.req = 4'b1001;
        cyc("wrap_idle");
        cyc("wrap_next");
        chk("wrap_grant", 32'(bus.grant), 32'h1);
        bus.req = 4'b0000;
        repeat (3) cyc("wrap_drain");

        // Reset in the middle of a write.
        do_reset();
        bus.req = 4'b0010;
        cyc("mid_w");
        chk("mid_enb_before", 32'(bus.regEnb), 32'h1);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("mid_async");
        chk("mid_enb_drop", 32'(bus.regEnb), 32'h0);
        cyc("mid_hold");
        reset = 1'b0;
        cyc("mid_regrant");
        chk("mid_regrant_grant", 32'(bus.grant), 32'h2);
        cyc("mid_ack");
        chk("mid_ack_pulse", 32'(bus.ack), 32'h2);
        bus.req = 4'b0000;
        repeat (2) cyc("mid_drain");

        // Random traffic against the reference.
        for (int c = 0; c < 400; c++) begin
            bus.req     = 4'($urandom);
            bus.lock    = 4'($urandom);
            bus.reqData = {$urandom, $urandom};
            reset       = ($urandom_range(0, 80) == 0);
            cyc("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
